wb_daq_data_disaggregation: RTL and testbench
=============================================

Name: wb_daq_data_disaggregation

Overview:
- Playback-side counterpart of the DAQ aggregation block.
- Pops packed 32-bit words from the playback FIFO and splits each into 8-, 16- or 32-bit samples.
- Presents one sample per DAC request strobe, LSB lane first, with one-cycle valid and underflow reporting.
- Sits between the WB-filled playback FIFO and the DAC interface logic.

Parameters:
- dw, 32: FIFO word width. Only 32 is supported.
- dac_dw, 32: dac_data width; the sample sits in the LSBs, upper bits extended.
- SYNC_STAGES, 3: depth of the dac_request delay/synchronizer shift register.

Ports:
- wb_clk  input  1  system clock; all logic is on the rising edge.
- wb_rst_n  input  1  asynchronous active-low reset.
- data_width  input  2  0=8-bit, 1=16-bit, 2=32-bit, 3=reserved.
- dac_request  input  1  one-cycle pulse; DAC wants the next sample.
- fifo_data_in  input  dw  FIFO read data, valid the cycle after fifo_pop.
- fifo_empty  input  1  FIFO empty flag.
- fifo_pop  output  1  one-cycle FIFO read strobe.
- dac_data  output  dac_dw  current sample; holds its value between valids.
- dac_valid  output  1  one-cycle strobe marking new dac_data.
- underflow  output  1  one-cycle pulse when a request finds no word held.
- underflow_sticky  output  1  latched underflow; cleared by underflow_clr.
- underflow_clr  input  1  clears underflow_sticky.

Behaviour:
- Reset (async assert, sync deassert on wb_clk): all outputs 0; state IDLE; lane index 0; shift register 0; held word 0.
- Request path: dac_request shifts through a SYNC_STAGES-bit register. req_local = last stage.
  - dac_valid or underflow is registered the cycle after req_local.
  - Request pulse to response latency is SYNC_STAGES+1 cycles (4 at default).
- FSM states:
  - IDLE: no word held. If !fifo_empty and data_width!=3, go to FETCH.
  - FETCH: fifo_pop=1 for exactly this cycle; go to LOAD.
  - LOAD: capture fifo_data_in into the word register; latch data_width into width_q; lane=0; go to HOLD.
  - HOLD: on req_local, output lane, pulse dac_valid, lane++. On the last lane (lane 3 for width 0, lane 1 for width 1, lane 0 for width 2), return to IDLE. IDLE refetches at once, so the pop comes 1 cycle after the last sample.
- Lane mapping:
  - width 0: lane n = word[8n+7:8n].
  - width 1: lane n = word[16n+15:16n].
  - width 2: the whole word.
  - Samples are zero-extended to dac_dw.
- Width changes: data_width is sampled only in LOAD. A change mid-word takes effect at the next word; the held word finishes at width_q.
- data_width==3 while IDLE: no pops. A request gives an underflow pulse with no dac_valid.
- Underflow: req_local in IDLE, FETCH or LOAD gives:
  - underflow=1 for one cycle and dac_valid=0;
  - dac_data unchanged, lane unchanged;
  - underflow_sticky set.
- Sticky priority: if underflow_clr and a new underflow occur in the same cycle, set wins.
- Back-to-back req_local in HOLD is legal; each consumes one lane.
- fifo_pop is never asserted while fifo_empty=1, nor outside FETCH.
- Only a reset aborts the held word; partial lanes are then discarded.

Optional Feature:
- Macro: DAQ_DISAGG_SIGN_EXT_EN.
  - Defined: 8- and 16-bit samples are sign-extended to dac_dw (for bipolar DACs).
  - Undefined: samples are zero-extended.
- 32-bit mode is unaffected either way.

Decomposition:
- Shared package wb_daq_pkg holds:
  - width codes DAQ_W8=2'd0, DAQ_W16=2'd1, DAQ_W32=2'd2, DAQ_WRSV=2'd3;
  - FSM state encodings;
  - last-lane constants per width.
- One natural sub-module: wb_daq_req_sync, the parameterized SYNC_STAGES shift register producing req_local.
- Lane mux and FSM stay in the top module.

Test Plan:
- FIFO holds 0x44332211, width 0, four requests:
  - dac_data = 0x11, 0x22, 0x33, 0x44, each with one dac_valid;
  - exactly one fifo_pop;
  - first valid 4 cycles after the first request.
- Words 0x44332211 then 0x88776655, width 1, four requests:
  - dac_data = 0x2211, 0x4433, 0x6655, 0x8877;
  - second pop 1 cycle after the 0x4433 valid.
- Width 2, empty FIFO, one request:
  - underflow pulse, underflow_sticky=1, dac_valid=0, dac_data stays 0, no fifo_pop;
  - then underflow_clr clears the sticky flag.
- Width switched 0→1 after two bytes of 0x44332211, two more requests:
  - dac_data = 0x33, 0x44;
  - the next word 0xBBBBAAAA gives 0xAAAA, 0xBBBB.
- wb_rst_n asserted mid-word (after 0x11 output):
  - all outputs 0 immediately;
  - after release, the next word is fetched at lane 0.
- Macro defined, width 0, word 0x0000_0080:
  - first sample dac_data = 0xFFFFFF80;
  - undefined, the same sample is 0x00000080.

Source files
------------

// File: rtl/wb_daq_pkg.sv
// Shared definitions for the DAQ playback-side blocks: sample width codes,
// disaggregation FSM encoding and per-width last-lane constants.
package wb_daq_pkg;

  localparam logic [1:0] DAQ_W8   = 2'd0;
  localparam logic [1:0] DAQ_W16  = 2'd1;
  localparam logic [1:0] DAQ_W32  = 2'd2;
  localparam logic [1:0] DAQ_WRSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_HOLD  = 2'd3
  } daq_state_e;

  localparam logic [1:0] LAST_LANE_W8  = 2'd3;
  localparam logic [1:0] LAST_LANE_W16 = 2'd1;
  localparam logic [1:0] LAST_LANE_W32 = 2'd0;

  // The reserved code can only reach the word register through a race with
  // LOAD; it is unpacked as a single 32-bit lane.
  function automatic logic [1:0] last_lane(input logic [1:0] width);
    logic [1:0] lane;
    case (width)
      DAQ_W8:  lane = LAST_LANE_W8;
      DAQ_W16: lane = LAST_LANE_W16;
      default: lane = LAST_LANE_W32;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/wb_daq_req_sync.sv
// Delay/synchronizer shift register for the DAC request strobe; the last
// stage is the request as seen by the disaggregation FSM.
module wb_daq_req_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic dac_request,
  output logic req_local
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= dac_request;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign req_local = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/wb_daq_data_disaggregation.sv
// Playback disaggregation: pops 32-bit FIFO words and hands them to the DAC
// one 8/16/32-bit lane per request. DAQ_DISAGG_SIGN_EXT_EN selects sign extension.
module wb_daq_data_disaggregation
  import wb_daq_pkg::*;
#(
  parameter int dw          = 32,
  parameter int dac_dw      = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic [1:0]        data_width,
  input  logic              dac_request,
  input  logic [dw-1:0]     fifo_data_in,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  output logic [dac_dw-1:0] dac_data,
  output logic              dac_valid,
  output logic              underflow,
  output logic              underflow_sticky,
  input  logic              underflow_clr
);

  function automatic logic [dac_dw-1:0] extend_sample(input logic [dw-1:0] word,
                                                      input logic [1:0]    width,
                                                      input logic [1:0]    lane);
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic signed [dac_dw-1:0] sample;
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = lane[0] ? word[31:16] : word[15:0];
    case (width)
`ifdef DAQ_DISAGG_SIGN_EXT_EN
      DAQ_W8:  sample = dac_dw'(byte_s);
      DAQ_W16: sample = dac_dw'(half_s);
`else
      DAQ_W8:  sample = dac_dw'($unsigned(byte_s));
      DAQ_W16: sample = dac_dw'($unsigned(half_s));
`endif
      default: sample = dac_dw'($unsigned(word));
    endcase
    return sample;
  endfunction

  logic              req_p0;
  daq_state_e        state_q, state_nxt;
  logic [dw-1:0]     word_q;
  logic [1:0]        width_q;
  logic [1:0]        lane_q;
  logic              pop_c, load_c, consume_c, uf_c;
  logic [dac_dw-1:0] data_p1;
  logic              vld_p1, uf_p1, sticky_q;

  wb_daq_req_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .dac_request(dac_request),
    .req_local  (req_p0)
  );

  always_comb begin
    state_nxt = state_q;
    pop_c     = 1'b0;
    load_c    = 1'b0;
    consume_c = 1'b0;
    uf_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && (data_width != DAQ_WRSV)) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        pop_c     = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_c    = 1'b1;
        state_nxt = ST_HOLD;
      end
      default: begin
        if (req_p0) begin
          consume_c = 1'b1;
          if (lane_q == last_lane(width_q)) state_nxt = ST_IDLE;
        end
      end
    endcase
    // A request arriving with no word held is reported, never silently dropped.
    if (req_p0 && (state_q != ST_HOLD)) uf_c = 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      width_q <= DAQ_W8;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_nxt;
      if (load_c) begin
        word_q  <= fifo_data_in;
        width_q <= data_width;
        lane_q  <= 2'd0;
      end else if (consume_c) begin
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  // ---- output stage p1: one cycle after req_local ----
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      uf_p1    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      vld_p1 <= consume_c;
      uf_p1  <= uf_c;
      if (consume_c) data_p1 <= extend_sample(word_q, width_q, lane_q);
      if (uf_c) sticky_q <= 1'b1;
      else if (underflow_clr) sticky_q <= 1'b0;
    end
  end

  assign fifo_pop         = pop_c;
  assign dac_data         = data_p1;
  assign dac_valid        = vld_p1;
  assign underflow        = uf_p1;
  assign underflow_sticky = sticky_q;

endmodule

// File: tb/tb_wb_daq_data_disaggregation.sv
// Scoreboard bench for wb_daq_data_disaggregation: directed words and requests,
// expected samples/underflows queued at stimulus time and checked by a monitor.
module tb_wb_daq_data_disaggregation;

  typedef struct packed {
    logic        uf;
    logic [31:0] data;
  } exp_t;

`ifdef DAQ_DISAGG_SIGN_EXT_EN
  localparam logic [31:0] EXP_80 = 32'hFFFF_FF80;
`else
  localparam logic [31:0] EXP_80 = 32'h0000_0080;
`endif

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [1:0]  data_width;
  logic        dac_request;
  logic [31:0] fifo_data_in;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [31:0] dac_data;
  logic        dac_valid;
  logic        underflow;
  logic        underflow_sticky;
  logic        underflow_clr;

  int n_cmp = 0;
  int n_err = 0;
  int pops  = 0;
  exp_t exp_q[$];
  logic [31:0] exp_last;

  logic [31:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 wb_clk = ~wb_clk;

  wb_daq_data_disaggregation dut (
    .wb_clk          (wb_clk),
    .wb_rst_n        (wb_rst_n),
    .data_width      (data_width),
    .dac_request     (dac_request),
    .fifo_data_in    (fifo_data_in),
    .fifo_empty      (fifo_empty),
    .fifo_pop        (fifo_pop),
    .dac_data        (dac_data),
    .dac_valid       (dac_valid),
    .underflow       (underflow),
    .underflow_sticky(underflow_sticky),
    .underflow_clr   (underflow_clr)
  );

  // FIFO model: read data appears the cycle after the pop.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge wb_clk) begin
    if (fifo_pop && !fifo_empty) begin
      fifo_data_in <= fifo_mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
    if (fifo_pop) pops <= pops + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every dac_valid/underflow strobe must match the next expectation.
  always @(negedge wb_clk) begin
    if (fifo_pop) check("pop_while_empty", {31'd0, fifo_empty}, 32'd0);
    if (dac_valid || underflow) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, dac_valid, underflow}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind", {30'd0, dac_valid, underflow}, {30'd0, ~e.uf, e.uf});
        check("dac_data", dac_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_sample(input logic [31:0] d);
    exp_q.push_back('{uf: 1'b0, data: d});
    exp_last = d;
  endtask

  task automatic expect_uf();
    exp_q.push_back('{uf: 1'b1, data: exp_last});
  endtask

  task automatic pulse_req();
    dac_request = 1'b1;
    tick();
    dac_request = 1'b0;
  endtask

  task automatic req_gap(input logic [31:0] d);
    expect_sample(d);
    pulse_req();
    repeat (6) tick();
  endtask

  // Returns the number of edges from the request edge until dac_valid is seen.
  task automatic req_wait_valid(output int lat);
    pulse_req();
    lat = 1;
    while (!dac_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    wb_rst_n      = 1'b0;
    data_width    = 2'd0;
    dac_request   = 1'b0;
    underflow_clr = 1'b0;
    fifo_data_in  = '0;
    exp_last      = '0;
    #1;
    check("rst_dac_data", dac_data, 32'd0);
    check("rst_outputs", {28'd0, dac_valid, underflow, underflow_sticky, fifo_pop}, 32'd0);
    repeat (3) tick();
    wb_rst_n = 1'b1;
    repeat (2) tick();

    // 8-bit lanes, first request with latency measurement, then back-to-back.
    push_word(32'h4433_2211);
    repeat (4) tick();
    expect_sample(32'h11);
    req_wait_valid(lat);
    check("latency_w8", lat, 32'd4);
    expect_sample(32'h22);
    expect_sample(32'h33);
    expect_sample(32'h44);
    dac_request = 1'b1;
    repeat (3) tick();
    dac_request = 1'b0;
    repeat (8) tick();
    check("pops_w8", pops, 32'd1);

    // 16-bit lanes across two words; refetch one cycle after the last valid.
    data_width = 2'd1;
    push_word(32'h4433_2211);
    push_word(32'h8877_6655);
    repeat (4) tick();
    req_gap(32'h2211);
    expect_sample(32'h4433);
    req_wait_valid(lat);
    check("latency_w16", lat, 32'd4);
    tick();
    check("refetch_pop", {31'd0, fifo_pop}, 32'd1);
    repeat (4) tick();
    req_gap(32'h6655);
    req_gap(32'h8877);
    check("pops_w16", pops, 32'd3);

    // Underflow with empty FIFO, sticky clear, then set-beats-clear.
    data_width = 2'd2;
    expect_uf();
    pulse_req();
    repeat (6) tick();
    check("sticky_set", {31'd0, underflow_sticky}, 32'd1);
    check("pops_uf", pops, 32'd3);
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    check("sticky_clr", {31'd0, underflow_sticky}, 32'd0);
    expect_uf();
    pulse_req();
    repeat (2) tick();
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    check("set_wins_pulse", {31'd0, underflow}, 32'd1);
    check("set_wins_sticky", {31'd0, underflow_sticky}, 32'd1);
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    repeat (2) tick();

    // Width change mid-word finishes the held word at its latched width.
    data_width = 2'd0;
    push_word(32'h4433_2211);
    repeat (4) tick();
    req_gap(32'h11);
    req_gap(32'h22);
    data_width = 2'd1;
    push_word(32'hBBBB_AAAA);
    repeat (4) tick();
    req_gap(32'h33);
    req_gap(32'h44);
    repeat (4) tick();
    req_gap(32'hAAAA);
    req_gap(32'hBBBB);
    check("pops_wchg", pops, 32'd5);

    // Reset mid-word discards remaining lanes.
    data_width = 2'd0;
    push_word(32'h4433_2211);
    repeat (4) tick();
    req_gap(32'h11);
    #2;
    wb_rst_n = 1'b0;
    #1;
    check("midrst_dac_data", dac_data, 32'd0);
    check("midrst_outputs", {28'd0, dac_valid, underflow, underflow_sticky, fifo_pop}, 32'd0);
    exp_last = '0;
    tick();
    wb_rst_n = 1'b1;
    repeat (2) tick();
    push_word(32'h0D0C_0B0A);
    repeat (4) tick();
    req_gap(32'h0A);
    req_gap(32'h0B);
    req_gap(32'h0C);
    req_gap(32'h0D);

    // Extension of an 8-bit sample with its MSB set.
    push_word(32'h0000_0080);
    repeat (4) tick();
    req_gap(EXP_80);

    repeat (10) tick();
    check("pops_total", pops, 32'd8);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
